// File: rtl/image_loader_pkg.sv
// Shared types and constants for the UART image loader.
// IMAGE_LOADER_CHECKSUM_EN adds the RX_CHK state to the loader FSM.
package image_loader_pkg;

  localparam logic [7:0] SYNC_BYTE          = 8'hA5;
  localparam int         DEFAULT_NUM_PIXELS = 784;

`ifdef IMAGE_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, RX_PIX, RX_CHK, START, WAIT_DONE, ERROR} loader_state_e;
`else
  typedef enum logic [2:0] {IDLE, RX_PIX, START, WAIT_DONE, ERROR} loader_state_e;
`endif

  typedef enum logic [1:0] {URX_IDLE, URX_START, URX_DATA, URX_STOP} urx_state_e;

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver with input synchronizer, start-bit glitch rejection and
// registered byte_valid / frame_err strobes one cycle after the stop sample.
module uart_rx
  import image_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       rxd,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);

  logic          rxd_meta_q, rxd_sync_q, rxd_prev_q;
  urx_state_e    state_q, state_d;
  logic [CW-1:0] clk_cnt_q, clk_cnt_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          byte_valid_q, byte_valid_d;
  logic          frame_err_q, frame_err_d;

  // Synchronizer resets to the idle-high line level so reset release is not a start edge.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rxd_meta_q   <= 1'b1;
      rxd_sync_q   <= 1'b1;
      rxd_prev_q   <= 1'b1;
      state_q      <= URX_IDLE;
      clk_cnt_q    <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      rxd_meta_q   <= rxd;
      rxd_sync_q   <= rxd_meta_q;
      rxd_prev_q   <= rxd_sync_q;
      state_q      <= state_d;
      clk_cnt_q    <= clk_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      byte_valid_q <= byte_valid_d;
      frame_err_q  <= frame_err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    clk_cnt_d    = clk_cnt_q + 1'b1;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    byte_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    unique case (state_q)
      URX_IDLE: begin
        clk_cnt_d = '0;
        if (rxd_prev_q && !rxd_sync_q) state_d = URX_START;
      end
      URX_START: begin
        if (clk_cnt_q == HALF_LAST) begin
          clk_cnt_d = '0;
          bit_cnt_d = '0;
          state_d   = rxd_sync_q ? URX_IDLE : URX_DATA;
        end
      end
      URX_DATA: begin
        if (clk_cnt_q == FULL_LAST) begin
          clk_cnt_d = '0;
          shift_d   = {rxd_sync_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == 3'd7) state_d = URX_STOP;
        end
      end
      URX_STOP: begin
        if (clk_cnt_q == FULL_LAST) begin
          clk_cnt_d    = '0;
          byte_valid_d = rxd_sync_q;
          frame_err_d  = !rxd_sync_q;
          state_d      = URX_IDLE;
        end
      end
      default: state_d = URX_IDLE;
    endcase
  end

  assign byte_valid = byte_valid_q;
  assign byte_data  = shift_q;
  assign frame_err  = frame_err_q;

endmodule

// File: rtl/image_loader.sv
// Receives a sync-prefixed pixel frame over UART, writes it to the network RAM,
// starts the network and captures its result. IMAGE_LOADER_CHECKSUM_EN adds a sum byte.
module image_loader
  import image_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT   = 434,
  parameter int NUM_PIXELS     = DEFAULT_NUM_PIXELS,
  parameter int TIMEOUT_CYCLES = 5000000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       uart_rxd,
  input  logic       nn_done,
  input  logic [3:0] nn_argmax,
  output logic       wr_en,
  output logic [9:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       nn_start,
  output logic       busy,
  output logic       result_valid,
  output logic [3:0] result,
  output logic       err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [9:0]    LAST_ADDR    = 10'(NUM_PIXELS - 1);

  logic       byte_valid, frame_err;
  logic [7:0] byte_data;

  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk       (clk),
    .resetn    (resetn),
    .rxd       (uart_rxd),
    .byte_valid(byte_valid),
    .byte_data (byte_data),
    .frame_err (frame_err)
  );

  loader_state_e state_q, state_d;
  logic [9:0]    cnt_q, cnt_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          wr_en_q, wr_en_d, nn_start_q, nn_start_d;
  logic [9:0]    wr_addr_q, wr_addr_d;
  logic [7:0]    wr_data_q, wr_data_d;
  logic          busy_q, busy_d, result_valid_q, result_valid_d, err_q, err_d;
  logic [3:0]    result_q, result_d;
  logic          timeout;
`ifdef IMAGE_LOADER_CHECKSUM_EN
  logic [7:0]    sum_q, sum_d;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      timer_q        <= '0;
      wr_en_q        <= 1'b0;
      wr_addr_q      <= '0;
      wr_data_q      <= '0;
      nn_start_q     <= 1'b0;
      busy_q         <= 1'b0;
      result_valid_q <= 1'b0;
      result_q       <= '0;
      err_q          <= 1'b0;
`ifdef IMAGE_LOADER_CHECKSUM_EN
      sum_q          <= '0;
`endif
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      timer_q        <= timer_d;
      wr_en_q        <= wr_en_d;
      wr_addr_q      <= wr_addr_d;
      wr_data_q      <= wr_data_d;
      nn_start_q     <= nn_start_d;
      busy_q         <= busy_d;
      result_valid_q <= result_valid_d;
      result_q       <= result_d;
      err_q          <= err_d;
`ifdef IMAGE_LOADER_CHECKSUM_EN
      sum_q          <= sum_d;
`endif
    end
  end

  assign timeout = (timer_q == TIMEOUT_LAST);

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    timer_d        = timer_q;
    wr_en_d        = 1'b0;
    wr_addr_d      = wr_addr_q;
    wr_data_d      = wr_data_q;
    nn_start_d     = 1'b0;
    busy_d         = busy_q;
    result_valid_d = result_valid_q;
    result_d       = result_q;
    err_d          = err_q;
`ifdef IMAGE_LOADER_CHECKSUM_EN
    sum_d          = sum_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (byte_valid && byte_data == SYNC_BYTE) begin
          state_d        = RX_PIX;
          cnt_d          = '0;
          timer_d        = '0;
          busy_d         = 1'b1;
          err_d          = 1'b0;
          result_valid_d = 1'b0;
`ifdef IMAGE_LOADER_CHECKSUM_EN
          sum_d          = '0;
`endif
        end
      end
      RX_PIX: begin
        timer_d = timer_q + 1'b1;
        // A byte wins over a same-cycle timeout; every byte here is pixel data.
        if (byte_valid) begin
          wr_en_d   = 1'b1;
          wr_addr_d = cnt_q;
          wr_data_d = byte_data;
          cnt_d     = cnt_q + 1'b1;
          timer_d   = '0;
`ifdef IMAGE_LOADER_CHECKSUM_EN
          sum_d     = sum_q + byte_data;
          if (cnt_q == LAST_ADDR) state_d = RX_CHK;
`else
          if (cnt_q == LAST_ADDR) state_d = START;
`endif
        end else if (frame_err || timeout) begin
          state_d = ERROR;
        end
      end
`ifdef IMAGE_LOADER_CHECKSUM_EN
      RX_CHK: begin
        timer_d = timer_q + 1'b1;
        if (byte_valid)                 state_d = (byte_data == sum_q) ? START : ERROR;
        else if (frame_err || timeout) state_d = ERROR;
      end
`endif
      START: begin
        nn_start_d = 1'b1;
        state_d    = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (nn_done) begin
          result_d       = nn_argmax;
          result_valid_d = 1'b1;
          busy_d         = 1'b0;
          state_d        = IDLE;
        end
      end
      ERROR: begin
        err_d   = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign wr_en        = wr_en_q;
  assign wr_addr      = wr_addr_q;
  assign wr_data      = wr_data_q;
  assign nn_start     = nn_start_q;
  assign busy         = busy_q;
  assign result_valid = result_valid_q;
  assign result       = result_q;
  assign err          = err_q;

endmodule

// File: tb/tb_image_loader.sv
// Directed bench for image_loader with a 4-pixel frame and an 8-cycle bit period.
module tb_image_loader;

  localparam int CPB  = 8;
  localparam int NPIX = 4;
  localparam int TMO  = 200;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       uart_rxd = 1'b1;
  logic       nn_done = 1'b0;
  logic [3:0] nn_argmax = '0;
  logic       wr_en, nn_start, busy, result_valid, err;
  logic [9:0] wr_addr;
  logic [7:0] wr_data;
  logic [3:0] result;

  int n_vec = 0;
  int n_err = 0;
  int wr_count = 0;
  int start_count = 0;
  logic [9:0] log_addr [64];
  logic [7:0] log_data [64];

  image_loader #(
    .CLKS_PER_BIT  (CPB),
    .NUM_PIXELS    (NPIX),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .uart_rxd    (uart_rxd),
    .nn_done     (nn_done),
    .nn_argmax   (nn_argmax),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .nn_start    (nn_start),
    .busy        (busy),
    .result_valid(result_valid),
    .result      (result),
    .err         (err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      log_addr[wr_count % 64] = wr_addr;
      log_data[wr_count % 64] = wr_data;
      wr_count++;
    end
    if (nn_start === 1'b1) start_count++;
  end

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    uart_rxd = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rxd = b[i];
      repeat (CPB) @(negedge clk);
    end
    uart_rxd = stop_bit;
    repeat (CPB) @(negedge clk);
    uart_rxd = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] p0, p1, p2, p3);
    logic [7:0] sum;
    sum = p0 + p1 + p2 + p3;
    send_byte(8'hA5, 1'b1);
    send_byte(p0, 1'b1);
    send_byte(p1, 1'b1);
    send_byte(p2, 1'b1);
    send_byte(p3, 1'b1);
`ifdef IMAGE_LOADER_CHECKSUM_EN
    send_byte(sum, 1'b1);
`else
    if (sum == 8'hFF) uart_rxd = 1'b1;
`endif
  endtask

  task automatic pulse_done(input logic [3:0] a);
    nn_argmax = a;
    nn_done = 1'b1;
    @(negedge clk);
    nn_done = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    uart_rxd = 1'b1;
    nn_done = 1'b0;
    repeat (4) @(negedge clk);
    resetn = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({wr_en, wr_addr, wr_data, nn_start, busy, result_valid, result, err} !== 27'd0) begin
      n_err++;
      $display("FAIL reset_outputs got %h want 0", {wr_en, wr_addr, wr_data, nn_start, busy, result_valid, result, err});
    end
    resetn = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_basic_frame();
    int wb, sb;
    wb = wr_count; sb = start_count;
    send_frame(8'h01, 8'h02, 8'h03, 8'h04);
    n_vec++;
    if (wr_count - wb !== 4) begin n_err++; $display("FAIL basic_wr_count got %0d want 4", wr_count - wb); end
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if (log_addr[(wb + i) % 64] !== 10'(i) || log_data[(wb + i) % 64] !== 8'(i + 1)) begin
        n_err++;
        $display("FAIL basic_wr%0d got addr %0d data %h want addr %0d data %h", i,
                 log_addr[(wb + i) % 64], log_data[(wb + i) % 64], i, i + 1);
      end
    end
    n_vec++;
    if (start_count - sb !== 1 || busy !== 1'b1) begin
      n_err++; $display("FAIL basic_start got starts %0d busy %b want 1 1", start_count - sb, busy);
    end
    send_byte(8'h55, 1'b1);
    n_vec++;
    if (wr_count - wb !== 4 || result_valid !== 1'b0) begin
      n_err++; $display("FAIL wait_drop got writes %0d rv %b want 4 0", wr_count - wb, result_valid);
    end
    pulse_done(4'd7);
    n_vec++;
    if (result !== 4'd7 || result_valid !== 1'b1 || busy !== 1'b0 || err !== 1'b0) begin
      n_err++; $display("FAIL basic_result got res %0d rv %b busy %b err %b want 7 1 0 0", result, result_valid, busy, err);
    end
  endtask

  task automatic test_reset_mid_frame();
    int wb, sb;
    send_byte(8'hA5, 1'b1);
    send_byte(8'h09, 1'b1);
    uart_rxd = 1'b0;
    repeat (CPB + CPB / 2) @(negedge clk);
    resetn = 1'b0;
    uart_rxd = 1'b1;
    @(negedge clk);
    n_vec++;
    if ({wr_en, wr_addr, wr_data, nn_start, busy, result_valid, result, err} !== 27'd0) begin
      n_err++;
      $display("FAIL midreset_outputs got %h want 0", {wr_en, wr_addr, wr_data, nn_start, busy, result_valid, result, err});
    end
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    repeat (4) @(negedge clk);
    wb = wr_count; sb = start_count;
    send_frame(8'h01, 8'h02, 8'h03, 8'h04);
    n_vec++;
    if (wr_count - wb !== 4 || start_count - sb !== 1 || log_addr[wb % 64] !== 10'd0) begin
      n_err++; $display("FAIL midreset_frame got writes %0d starts %0d addr0 %0d want 4 1 0",
                        wr_count - wb, start_count - sb, log_addr[wb % 64]);
    end
    pulse_done(4'd2);
    n_vec++;
    if (result !== 4'd2 || result_valid !== 1'b1 || busy !== 1'b0) begin
      n_err++; $display("FAIL midreset_result got res %0d rv %b busy %b want 2 1 0", result, result_valid, busy);
    end
  endtask

  task automatic test_sync_filter_glitch();
    int wb;
    wb = wr_count;
    send_byte(8'h3C, 1'b1);
    send_byte(8'h11, 1'b1);
    n_vec++;
    if (wr_count - wb !== 0 || busy !== 1'b0) begin
      n_err++; $display("FAIL nosync_ignore got writes %0d busy %b want 0 0", wr_count - wb, busy);
    end
    uart_rxd = 1'b0;
    @(negedge clk);
    uart_rxd = 1'b1;
    repeat (12 * CPB) @(negedge clk);
    send_byte(8'hA5, 1'b1);
    n_vec++;
    if (busy !== 1'b1) begin n_err++; $display("FAIL glitch_then_sync got busy %b want 1", busy); end
    do_reset();
  endtask

  task automatic test_pixel_a5();
    int wb, sb;
    wb = wr_count; sb = start_count;
    send_frame(8'h01, 8'h02, 8'hA5, 8'h04);
    n_vec++;
    if (log_addr[(wb + 2) % 64] !== 10'd2 || log_data[(wb + 2) % 64] !== 8'hA5) begin
      n_err++; $display("FAIL pix_a5_write got addr %0d data %h want 2 a5", log_addr[(wb + 2) % 64], log_data[(wb + 2) % 64]);
    end
    n_vec++;
    if (wr_count - wb !== 4 || log_addr[(wb + 3) % 64] !== 10'd3 || start_count - sb !== 1) begin
      n_err++; $display("FAIL pix_a5_continue got writes %0d addr3 %0d starts %0d want 4 3 1",
                        wr_count - wb, log_addr[(wb + 3) % 64], start_count - sb);
    end
    pulse_done(4'd3);
  endtask

  task automatic test_frame_err();
    int wb, sb;
    wb = wr_count; sb = start_count;
    send_byte(8'hA5, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h02, 1'b0);
    repeat (20) @(negedge clk);
    n_vec++;
    if (err !== 1'b1 || busy !== 1'b0 || start_count - sb !== 0 || wr_count - wb !== 1) begin
      n_err++; $display("FAIL stop_err got err %b busy %b starts %0d writes %0d want 1 0 0 1",
                        err, busy, start_count - sb, wr_count - wb);
    end
  endtask

  task automatic test_timeout();
    int sb;
    sb = start_count;
    send_byte(8'hA5, 1'b1);
    n_vec++;
    if (err !== 1'b0 || busy !== 1'b1) begin
      n_err++; $display("FAIL sync_clears_err got err %b busy %b want 0 1", err, busy);
    end
    send_byte(8'h01, 1'b1);
    send_byte(8'h02, 1'b1);
    repeat (TMO + 10) @(negedge clk);
    n_vec++;
    if (err !== 1'b1 || busy !== 1'b0 || start_count - sb !== 0) begin
      n_err++; $display("FAIL timeout got err %b busy %b starts %0d want 1 0 0", err, busy, start_count - sb);
    end
    send_byte(8'hA5, 1'b1);
    n_vec++;
    if (err !== 1'b0 || busy !== 1'b1) begin
      n_err++; $display("FAIL timeout_resync got err %b busy %b want 0 1", err, busy);
    end
    do_reset();
  endtask

`ifdef IMAGE_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    int sb;
    sb = start_count;
    send_byte(8'hA5, 1'b1);
    for (int i = 1; i <= 4; i++) send_byte(8'(i), 1'b1);
    send_byte(8'h0A, 1'b1);
    n_vec++;
    if (start_count - sb !== 1 || err !== 1'b0) begin
      n_err++; $display("FAIL chk_good got starts %0d err %b want 1 0", start_count - sb, err);
    end
    pulse_done(4'd5);
    sb = start_count;
    send_byte(8'hA5, 1'b1);
    for (int i = 1; i <= 4; i++) send_byte(8'(i), 1'b1);
    send_byte(8'h0B, 1'b1);
    n_vec++;
    if (start_count - sb !== 0 || err !== 1'b1 || busy !== 1'b0) begin
      n_err++; $display("FAIL chk_bad got starts %0d err %b busy %b want 0 1 0", start_count - sb, err, busy);
    end
  endtask
`endif

  initial begin
    repeat (2) @(negedge clk);
    test_reset();
    test_basic_frame();
    test_reset_mid_frame();
    test_sync_filter_glitch();
    test_pixel_a5();
    test_frame_err();
    test_timeout();
`ifdef IMAGE_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/image_loader.md
IMAGE_LOADER -- requirements
Module: image_loader

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 434, meaning UART bit period in clk cycles (50 MHz / 115200).
REQ-002 SHALL have parameter NUM_PIXELS, default 784, meaning pixel bytes per image (28x28).
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 5000000, meaning maximum clk cycles between bytes inside a frame.
REQ-004 SHALL use one clock and an asynchronous, active-low reset, with the ports listed below.
REQ-005 Port clk  input  1  system clock, all logic on its rising edge.
REQ-006 Port resetn  input  1  asynchronous active-low reset.
REQ-007 Port uart_rxd  input  1  asynchronous UART serial input, 8N1, idle high.
REQ-008 Port nn_done  input  1  network done, level or pulse.
REQ-009 Port nn_argmax  input  4  network classification result, valid while nn_done=1.
REQ-010 Port wr_en  output  1  one-cycle write strobe to the network input RAM.
REQ-011 Port wr_addr  output  10  pixel address, 0..NUM_PIXELS-1.
REQ-012 Port wr_data  output  8  pixel value.
REQ-013 Port nn_start  output  1  one-cycle start pulse to the network.
REQ-014 Port busy  output  1  high from sync byte accepted until result captured or error.
REQ-015 Port result_valid  output  1  high while result holds a valid classification.
REQ-016 Port result  output  4  captured argmax, for the HEX display.
REQ-017 Port err  output  1  sticky error flag, cleared by the next accepted sync byte.

Function
REQ-018 uart_rxd SHALL pass through a 2-flop synchronizer before any use.
REQ-019 Receiver SHALL detect the start bit on a synchronized 1->0 edge while idle.
REQ-020 Receiver SHALL re-sample at CLKS_PER_BIT/2 and abort silently if the line is high (glitch).
REQ-021 Receiver SHALL sample 8 data bits LSB first at mid-bit, then the stop bit.
REQ-022 Receiver SHALL emit byte_valid one cycle after the stop sample if stop=1, otherwise emit frame_err.
REQ-023 Loader FSM states: IDLE, RX_PIX, RX_CHK, START, WAIT_DONE, ERROR.
REQ-024 In IDLE, byte 0xA5 SHALL go to RX_PIX, clear the pixel counter, set busy, and clear err and result_valid; other bytes SHALL be ignored.
REQ-025 In RX_PIX, each byte SHALL produce wr_en=1 for exactly one cycle, the cycle after byte_valid, with wr_addr=counter and wr_data=byte; the counter then increments.
REQ-026 After the byte at address NUM_PIXELS-1 is written, the FSM SHALL go to RX_CHK if CHECKSUM_EN is defined, otherwise to START.
REQ-027 START SHALL assert nn_start for exactly one cycle, then go to WAIT_DONE.
REQ-028 In WAIT_DONE, on nn_done=1 the block SHALL latch nn_argmax into result, set result_valid, clear busy, and go to IDLE.
REQ-029 In WAIT_DONE, UART bytes SHALL be ignored (dropped, not queued).
REQ-030 In RX_PIX or RX_CHK, frame_err or TIMEOUT_CYCLES elapsed without a byte SHALL go to ERROR.
REQ-031 ERROR SHALL set err, clear busy, and return to IDLE on the next cycle; no nn_start is issued.
REQ-032 If 0xA5 arrives inside RX_PIX, it SHALL be treated as pixel data, not as a resync.

Reset
REQ-033 On resetn=0: FSM=IDLE, receiver idle, counter=0, and wr_en, nn_start, busy, result_valid, err=0, wr_addr=0, wr_data=0, result=0.
REQ-034 Reset mid-frame SHALL discard the partial image; RAM contents are not cleared.

Configuration
REQ-035 Macro IMAGE_LOADER_CHECKSUM_EN defined: in RX_CHK, one extra byte is compared with the 8-bit modulo-256 sum of all pixels; on match go to START, on mismatch go to ERROR.
REQ-036 Macro undefined: no RX_CHK state and no sum register; the block goes straight from the last pixel to START.

Structure
REQ-037 A shared package SHALL hold the state enum, SYNC_BYTE=8'hA5, and the default NUM_PIXELS.
REQ-038 The UART receiver SHALL be a sub-module uart_rx (ports clk, resetn, rxd, byte_valid, byte_data, frame_err, parameter CLKS_PER_BIT).

Verification
REQ-039 Reset mid-bit during a frame -> all outputs 0, FSM IDLE; a following full frame completes normally.
REQ-040 CLKS_PER_BIT=8, NUM_PIXELS=4; send A5 01 02 03 04 -> wr_en x4 with addr 0..3 and data 01..04, one nn_start; nn_done with argmax=7 -> result=7, result_valid=1, busy=0.
REQ-041 0x3C before A5 -> no writes; 1-cycle low glitch on rxd -> no byte; stop bit=0 mid-frame -> err=1, no nn_start.
REQ-042 Send A5 then 2 pixels and go silent for TIMEOUT_CYCLES+1 -> err=1, busy=0; next A5 clears err.
REQ-043 CHECKSUM_EN with A5 01 02 03 04 0A -> nn_start; trailing 0B instead -> err=1, no nn_start.
REQ-044 Pixel value A5 at address 2 -> written as data, frame continues to address 3.
